// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - fan auto-off minutes:seconds countdown driven by the 1 s tick
// Commands resolve in priority order cancel > pause > load > start > tick_1s.
module countdown_timer #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [5:0] remain_min,
  output logic [5:0] remain_sec,
  output logic       running,
  output logic       paused,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] min_d;
  logic [5:0] sec_d;
  logic       expired_d;
  logic       at_zero;

  assign at_zero = (remain_min == 6'd0) && (remain_sec == 6'd0);

  always_comb begin
    state_d   = state_q;
    min_d     = remain_min;
    sec_d     = remain_sec;
    expired_d = 1'b0;

    if (cancel) begin
      state_d = IDLE;
      min_d   = 6'd0;
      sec_d   = 6'd0;
    end else if (pause) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (load) begin
      if (state_q != RUN) begin
        min_d = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
        sec_d = 6'd0;
      end
    end else if (start) begin
      if (state_q != RUN && !at_zero) begin
        state_d = RUN;
      end
    end else if (tick_1s && state_q == RUN && !at_zero) begin
      if (remain_sec != 6'd0) begin
        sec_d = remain_sec - 6'd1;
      end else begin
        min_d = remain_min - 6'd1;
        sec_d = 6'd59;
      end
      // The tick that lands on 0:00 ends the run on the same edge.
      if (remain_min == 6'd0 && remain_sec == 6'd1) begin
        state_d   = IDLE;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      remain_min <= 6'd0;
      remain_sec <= 6'd0;
      running    <= 1'b0;
      paused     <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_min <= min_d;
      remain_sec <= sec_d;
      running    <= (state_d == RUN);
      paused     <= (state_d == PAUSE);
      expired    <= expired_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer
// Every expected output change is queued; the monitor pops one per observed change.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       tick_1s;
  logic       load;
  logic [5:0] load_min;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [5:0] remain_min;
  logic [5:0] remain_sec;
  logic       running;
  logic       paused;
  logic       expired;

  countdown_timer #(.MAX_MIN(59)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1s    (tick_1s),
    .load       (load),
    .load_min   (load_min),
    .start      (start),
    .pause      (pause),
    .cancel     (cancel),
    .remain_min (remain_min),
    .remain_sec (remain_sec),
    .running    (running),
    .paused     (paused),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [14:0] exp_q[$];
  string       name_q[$];
  logic        mon_en = 1'b0;
  logic [14:0] prev;

  int   em, es;
  logic er, ep;

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d run=%b pau=%b exp=%b, want %0d:%0d run=%b pau=%b exp=%b",
               name, act[14:9], act[8:3], act[2], act[1], act[0],
               want[14:9], want[8:3], want[2], want[1], want[0]);
    end
  endtask

  function automatic logic [14:0] outs();
    return {remain_min, remain_sec, running, paused, expired};
  endfunction

  // Monitor: any change in the outputs must match the next queued expectation.
  always @(negedge clk) begin
    logic [14:0] cur;
    cur = outs();
    if (mon_en && cur !== prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", cur, prev);
      end else begin
        check(name_q.pop_front(), cur, exp_q.pop_front());
      end
    end
    prev = cur;
  end

  task automatic expect_out(input string name, input int m, input int s,
                            input logic r, input logic p, input logic x);
    em = m; es = s; er = r; ep = p;
    exp_q.push_back({6'(m), 6'(s), r, p, x});
    name_q.push_back(name);
  endtask

  task automatic step(input logic ld, input logic st, input logic pa,
                      input logic ca, input logic tk);
    load = ld; start = st; pause = pa; cancel = ca; tick_1s = tk;
    @(posedge clk);
    #1;
    load = 0; start = 0; pause = 0; cancel = 0; tick_1s = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int m);
    load_min = 6'(m);
    step(1, 0, 0, 0, 0);
  endtask

  // Ticks while running; expectations follow plain mm:ss countdown arithmetic.
  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (em == 0 && es == 1) begin
        expect_out("expire_edge", 0, 0, 0, 0, 1);
        expect_out("expire_end", 0, 0, 0, 0, 0);
      end else if (es > 0) begin
        expect_out("tick_sec", em, es - 1, er, ep, 0);
      end else begin
        expect_out("tick_min", em - 1, 59, er, ep, 0);
      end
      step(0, 0, 0, 0, 1);
      idle(gap - 1);
    end
  endtask

  task automatic idle_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 1);
      idle(gap - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick_1s = 0; load = 0; load_min = 6'd0; start = 0; pause = 0; cancel = 0;
    em = 0; es = 0; er = 0; ep = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 15'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 1: two-minute run to expiry
    expect_out("t1_load", 2, 0, 0, 0, 0);
    do_load(2);
    expect_out("t1_start", 2, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    run_ticks(120, 100);
    idle_ticks(3, 10);
    check("t1_after_expire", outs(), {6'd0, 6'd0, 1'b0, 1'b0, 1'b0});

    // 2: saturating load, zero load, start at 0:00 ignored
    expect_out("t2_sat", 59, 0, 0, 0, 0);
    do_load(63);
    expect_out("t2_zero", 0, 0, 0, 0, 0);
    do_load(0);
    step(0, 1, 0, 0, 0);
    idle(3);
    check("t2_start_zero", outs(), {6'd0, 6'd0, 1'b0, 1'b0, 1'b0});

    // 3: pause holds through ticks, resume continues
    expect_out("t3_load", 1, 0, 0, 0, 0);
    do_load(1);
    expect_out("t3_start", 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    expect_out("t3_pause", 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    idle_ticks(300, 10);
    check("t3_paused_hold", outs(), {6'd1, 6'd0, 1'b0, 1'b1, 1'b0});
    expect_out("t3_resume", 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    run_ticks(1, 10);
    check("t3_first_tick", outs(), {6'd0, 6'd59, 1'b1, 1'b0, 1'b0});
    expect_out("t3_cancel", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // 4: pause wins over a same-cycle tick, then cancel
    expect_out("t4_load", 1, 0, 0, 0, 0);
    do_load(1);
    expect_out("t4_start", 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    run_ticks(55, 10);
    expect_out("t4_pause_tick", 0, 5, 0, 1, 0);
    step(0, 0, 1, 0, 1);
    expect_out("t4_cancel", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(3);

    // 5: cancel beats the final tick; load in RUN ignored
    expect_out("t5_load", 1, 0, 0, 0, 0);
    do_load(1);
    expect_out("t5_start", 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    run_ticks(59, 10);
    expect_out("t5_cancel_tick", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    idle(3);
    expect_out("t5_load2", 1, 0, 0, 0, 0);
    do_load(1);
    expect_out("t5_start2", 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    run_ticks(30, 10);
    do_load(5);
    idle(2);
    check("t5_load_in_run", outs(), {6'd0, 6'd30, 1'b1, 1'b0, 1'b0});
    expect_out("t5_cancel", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // 6: asynchronous reset mid-count
    expect_out("t6_load", 4, 0, 0, 0, 0);
    do_load(4);
    expect_out("t6_start", 4, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    run_ticks(43, 10);
    check("t6_at_3_17", outs(), {6'd3, 6'd17, 1'b1, 1'b0, 1'b0});
    expect_out("t6_reset_mon", 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_reset_immediate", outs(), 15'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_ticks(5, 10);
    check("t6_idle_after_reset", outs(), 15'd0);

    idle(3);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
